// File: rtl/i2c_eeprom_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_responder_pkg
//  Description : Shared I2C definitions: responder state encoding, default
//                device address, control-byte constants, pointer helper.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_eeprom_responder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_WORD_ADDR = 4'd3,
    ST_WORD_ACK  = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD_DATA   = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  localparam logic [6:0] C_DEV_ADDR_DEFAULT = 7'h50;
  localparam logic [7:0] C_CTRL_WR          = {C_DEV_ADDR_DEFAULT, 1'b0};
  localparam logic [7:0] C_CTRL_RD          = {C_DEV_ADDR_DEFAULT, 1'b1};

  // Word pointer advance with wrap at the last implemented location
  function automatic logic [3:0] ptr_next(input logic [3:0] ptr, input logic [3:0] last);
    return (ptr == last) ? 4'd0 : ptr + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_eeprom_responder_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sync
//  Description : Two-flop synchronisers for SCL/SDA plus history flops;
//                produces SCL edge strobes and START/STOP detection.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_bus_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  // Synchronise both bus lines and keep one cycle of history; idle bus is high
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign sda_o       = sda_sync_q;
  assign scl_rise_o  =  scl_sync_q & ~scl_prev_q;
  assign scl_fall_o  = ~scl_sync_q &  scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP
  assign start_det_o = scl_sync_q & scl_prev_q &  sda_prev_q & ~sda_sync_q;
  assign stop_det_o  = scl_sync_q & scl_prev_q & ~sda_prev_q &  sda_sync_q;

endmodule
`default_nettype wire

// File: rtl/i2c_eeprom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_responder
//  Description : I2C slave emulating a small byte-addressed EEPROM with
//                auto-incrementing word pointer and a debug read port.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_eeprom_responder
  import i2c_eeprom_responder_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = C_DEV_ADDR_DEFAULT,
  parameter int         MEM_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  input  logic [3:0] DBG_ADDR,
  output logic [7:0] DBG_DATA,
  output logic       WR_STROBE,
  output logic       BUSY
);

  localparam logic [3:0] C_PTR_LAST = 4'(MEM_DEPTH - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .CLK         (CLK),
    .RESET       (RESET),
    .scl_i       (SCL_IN),
    .sda_i       (SDA_IN),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  state_t     state_q;
  logic [3:0] bitcnt_q;
  logic [3:0] ptr_q;
  logic [7:0] shreg_q;
  logic       rw_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       wr_strobe_q;
  logic [3:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] mem_q [MEM_DEPTH];

  logic [7:0] rx_byte;
  logic [3:0] ptr_inc;
  logic       byte_done;

  assign rx_byte   = {shreg_q[6:0], sda_s};
  assign ptr_inc   = ptr_next(ptr_q, C_PTR_LAST);
  assign byte_done = (bitcnt_q == 4'd7);

  // Protocol FSM; memory commit lags WR_STROBE by one cycle so DBG_DATA shows the old byte during the pulse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 4'd0;
      ptr_q       <= 4'd0;
      shreg_q     <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_strobe_q <= 1'b0;
      if (wr_strobe_q) mem_q[wr_addr_q] <= wr_data_q;

      if (stop_det) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= 4'd0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q  <= ST_DEV_ADDR;
        bitcnt_q <= 4'd0;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_IGNORE: begin
          end
          ST_DEV_ADDR: if (scl_rise) begin
            shreg_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (byte_done) begin
              bitcnt_q <= 4'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_q <= ST_DEV_ACK;
                rw_q    <= rx_byte[0];
                busy_q  <= 1'b1;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          ST_WORD_ADDR: if (scl_rise) begin
            shreg_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (byte_done) begin
              bitcnt_q <= 4'd0;
              ptr_q    <= rx_byte[3:0];
              state_q  <= ST_WORD_ACK;
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            shreg_q  <= rx_byte;
            bitcnt_q <= bitcnt_q + 4'd1;
            if (byte_done) begin
              bitcnt_q    <= 4'd0;
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= ptr_q;
              wr_data_q   <= rx_byte;
              ptr_q       <= ptr_inc;
              state_q     <= ST_WR_ACK;
            end
          end
          // First SCL fall asserts the ACK, the second (end of 9th pulse) releases it
          ST_DEV_ACK, ST_WORD_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else if (state_q == ST_DEV_ACK && rw_q) begin
              state_q  <= ST_RD_DATA;
              shreg_q  <= mem_q[ptr_q];
              sda_oe_q <= ~mem_q[ptr_q][7];
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= (state_q == ST_DEV_ACK) ? ST_WORD_ADDR : ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) bitcnt_q <= bitcnt_q + 4'd1;
            if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= 4'd0;
                state_q  <= ST_RD_ACK;
              end else begin
                shreg_q  <= {shreg_q[6:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
              end
            end
          end
          // bitcnt_q==1 marks "master ACKed, next byte loaded, drive on the coming fall"
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state_q <= ST_IGNORE;
              end else begin
                ptr_q    <= ptr_inc;
                shreg_q  <= mem_q[ptr_inc];
                bitcnt_q <= 4'd1;
              end
            end else if (scl_fall && bitcnt_q == 4'd1) begin
              bitcnt_q <= 4'd0;
              sda_oe_q <= ~shreg_q[7];
              state_q  <= ST_RD_DATA;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign SDA_OE    = sda_oe_q;
  assign WR_STROBE = wr_strobe_q;
  assign BUSY      = busy_q;
  assign DBG_DATA  = mem_q[DBG_ADDR];

endmodule
`default_nettype wire
